// File: rtl/filter_decimator_pkg.sv
// Shared constants for the filter chain: default sample width, buffer depth
// and the decimation-factor width, plus the effective-factor helper.
package filter_decimator_pkg;

    localparam int DEFAULT_N     = 16;
    localparam int DEFAULT_DEPTH = 8;
    localparam int DECIM_W       = 4;

    typedef logic [DECIM_W-1:0] decim_t;

    // A programmed factor of 0 behaves as 1 (keep every sample).
    function automatic decim_t eff_factor(input decim_t d);
        return (d == '0) ? decim_t'(1) : d;
    endfunction

endpackage

// File: rtl/filter_decimator_sample_fifo.sv
// Circular sample buffer with occupancy count. Pointers wrap naturally
// because DEPTH is a power of two; storage itself carries no reset.
module sample_fifo #(
    parameter int N     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [N-1:0]             wr_data,
    output logic [N-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
    localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fill <= fill + FILL_ONE;
                2'b01:   fill <= fill - FILL_ONE;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    assign full    = (fill == FILL_MAX);
    assign empty   = (fill == '0);
    // Stale memory contents never leak out while nothing is buffered.
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/filter_decimator.sv
// Keeps every Meff-th valid filter sample, buffers kept samples for a
// ready/valid consumer, and flags kept samples lost to a full buffer.
module filter_decimator
    import filter_decimator_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [N-1:0]             in_data,
    input  logic [DECIM_W-1:0]       decim,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam decim_t PH_ONE = decim_t'(1);

    decim_t ph;
    logic   keep;
    logic   push;
    logic   pop;
    logic   drop;
    logic   full;
    logic   empty;

    assign keep      = in_valid && (ph == '0);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A pop on a full buffer frees the slot the kept sample lands in.
    assign push      = keep && (!full || pop);
    assign drop      = keep && full && !pop;

    // decim is only looked at on keep cycles, so a change applies after
    // the next kept sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ph <= '0;
        else if (in_valid)
            ph <= keep ? (eff_factor(decim) - PH_ONE) : (ph - PH_ONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clr_overflow)
            overflow <= 1'b0;
    end

    sample_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (out_data),
        .fill    (fill),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_filter_decimator.sv
// Directed bench for filter_decimator: decimation phases, ready/valid
// draining, full-buffer behaviour, sticky overflow and mid-stream reset.
module tb_filter_decimator;

    localparam int N     = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic [3:0]    decim;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [3:0]    fill;
    logic          overflow;
    logic          clr_overflow;

    int checks   = 0;
    int failures = 0;

    filter_decimator #(.N(N), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .decim        (decim),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .fill         (fill),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; decim = 4'd1;
        out_ready = 1'b0; clr_overflow = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data), 0);
        chk("rst_fill",      32'(fill), 0);
        chk("rst_overflow",  32'(overflow), 0);
        chk("rst_ph",        32'(dut.ph), 0);
        reset = 1'b0;

        // decim=3, continuous input 1..12, consumer always ready
        decim = 4'd3; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            in_data = 16'(i);
            tick();
            if ((i % 3) == 1) begin
                chk("d3_valid", 32'(out_valid), 1);
                chk("d3_data",  32'(out_data), 32'(i));
            end else begin
                chk("d3_idle_valid", 32'(out_valid), 0);
                chk("d3_idle_data",  32'(out_data), 0);
            end
        end
        in_valid = 1'b0;
        tick();

        // decim=0 acts as 1; idle cycles do not advance the phase
        do_reset();
        decim = 4'd0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0005; tick();
        chk("d0_fill_a", 32'(fill), 1);
        chk("d0_ph_a",   32'(dut.ph), 0);
        in_valid = 1'b0; in_data = 16'h00AA; tick();
        chk("d0_fill_b", 32'(fill), 1);
        chk("d0_ph_b",   32'(dut.ph), 0);
        in_valid = 1'b1; in_data = 16'h0006; tick();
        chk("d0_fill_c", 32'(fill), 2);
        chk("d0_ph_c",   32'(dut.ph), 0);
        in_valid = 1'b0; in_data = 16'h00BB; tick();
        chk("d0_fill_d", 32'(fill), 2);
        chk("d0_head0",  32'(out_data), 32'h5);
        out_ready = 1'b1; tick();
        chk("d0_head1",  32'(out_data), 32'h6);
        tick();
        chk("d0_empty",  32'(out_valid), 0);
        out_ready = 1'b0;

        // overfill with consumer stalled: 9th sample is dropped
        do_reset();
        decim = 4'd1; in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 16'(16'h10 + i);
            tick();
            if (i == 7) begin
                chk("ovf_fill8", 32'(fill), 8);
                chk("ovf_not_yet", 32'(overflow), 0);
            end
        end
        chk("ovf_fill_after9", 32'(fill), 8);
        chk("ovf_set", 32'(overflow), 1);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("ovf_drain_valid", 32'(out_valid), 1);
            chk("ovf_drain_data",  32'(out_data), 32'(16'h10 + k));
            tick();
        end
        chk("ovf_drained_valid", 32'(out_valid), 0);
        chk("ovf_drained_fill",  32'(fill), 0);
        chk("ovf_sticky",        32'(overflow), 1);
        out_ready = 1'b0;

        // clear alone, then refill and drop in the same cycle as a clear
        clr_overflow = 1'b1; tick();
        chk("clr_alone_a", 32'(overflow), 0);
        clr_overflow = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 16'(16'h20 + i);
            tick();
        end
        chk("clr_refill", 32'(fill), 8);
        in_data = 16'h0028; clr_overflow = 1'b1; tick();
        chk("clr_set_wins", 32'(overflow), 1);
        in_valid = 1'b0; tick();
        chk("clr_alone_b", 32'(overflow), 0);
        clr_overflow = 1'b0;

        // full buffer, keep and pop every cycle across the pointer wrap
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_data = 16'(16'h30 + k);
            chk("wrap_head", 32'(out_data), (k < 8) ? 32'(16'h20 + k) : 32'(16'h30 + k - 8));
            tick();
            chk("wrap_fill", 32'(fill), 8);
            chk("wrap_ovf",  32'(overflow), 0);
        end
        in_valid = 1'b0;
        for (int k = 4; k < 12; k++) begin
            chk("wrap_drain", 32'(out_data), 32'(16'h30 + k));
            tick();
        end
        chk("wrap_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        // asynchronous reset with 5 samples buffered and phase mid-count
        do_reset();
        decim = 4'd2; in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 16'(16'h40 + i);
            tick();
        end
        chk("mid_fill5", 32'(fill), 5);
        chk("mid_ph1",   32'(dut.ph), 1);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_fill",  32'(fill), 0);
        #2 reset = 1'b0;
        in_valid = 1'b1; in_data = 16'h0077;
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_data",  32'(out_data), 32'h77);
        chk("post_rst_fill",  32'(fill), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
